// File: rtl/tl_pkg.sv
// Shared phase, mode and lamp encodings for the traffic-light phase controller,
// plus small arithmetic helpers used by the controller.
package tl_pkg;

  typedef enum logic [3:0] {
    NS_GREEN  = 4'd0,
    NS_YELLOW = 4'd1,
    ALLRED_A  = 4'd2,
    EW_GREEN  = 4'd3,
    EW_YELLOW = 4'd4,
    ALLRED_B  = 4'd5,
    FLASH     = 4'd6
  } phase_e;

  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_ACT   = 2'b01;

  // Lamp encoding is {R,Y,G}
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a - b : 8'd0;
  endfunction

  // Green termination on a tick; flash modes never reach here (flash entry wins).
  function automatic logic green_done(input logic [1:0] mode, input logic own, input logic opp,
                                      input logic [7:0] el, input logic [7:0] gmin,
                                      input logic [7:0] gmax);
    if (mode == MODE_FIXED) return el >= gmax - 8'd1;
    return opp && ((el >= gmin - 8'd1 && !own) || el >= gmax - 8'd1);
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase elapsed-tick counter: cleared on phase entry, counts ticks, saturates at 255.
module tl_phase_timer
  import tl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  output logic [7:0] elapsed,
  output logic [7:0] elapsed_nxt
);

  always_comb begin
    elapsed_nxt = elapsed;
    if (clr)
      elapsed_nxt = '0;
    else if (tick && elapsed != 8'hFF)
      elapsed_nxt = elapsed + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) elapsed <= '0;
    else     elapsed <= elapsed_nxt;
  end

endmodule

// File: rtl/tl_phase_ctrl.sv
// Two-approach traffic-light phase controller (fixed / actuated / flash).
// Define TL_ALLRED_EN to insert all-red clearance phases after each yellow.
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter logic [7:0] GREEN_MIN = 8'd5,
  parameter logic [7:0] GREEN_MAX = 8'd20,
  parameter logic [7:0] YELLOW_T  = 8'd3,
  parameter logic [7:0] ALLRED_T  = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] mode_sel,
  input  logic       veh_NS,
  input  logic       veh_EW,
  output logic [3:0] phase_id,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic [7:0] time_left,
  output logic       phase_start
);

`ifdef TL_ALLRED_EN
  localparam phase_e NS_Y_NEXT  = ALLRED_A;
  localparam phase_e EW_Y_NEXT  = ALLRED_B;
  localparam phase_e FLASH_NEXT = ALLRED_B;
`else
  localparam phase_e NS_Y_NEXT  = EW_GREEN;
  localparam phase_e EW_Y_NEXT  = NS_GREEN;
  localparam phase_e FLASH_NEXT = NS_GREEN;
`endif

  phase_e     phase, phase_nxt;
  logic       blink, blink_nxt;
  logic [7:0] elapsed, elapsed_nxt;
  logic [2:0] ns_lamp_nxt, ew_lamp_nxt;
  logic [7:0] time_left_nxt;
  logic       enter;

  assign enter    = (phase_nxt != phase);
  assign phase_id = phase;

  tl_phase_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (enter),
    .tick        (tick),
    .elapsed     (elapsed),
    .elapsed_nxt (elapsed_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= NS_GREEN;
      blink       <= 1'b0;
      ns_lamp     <= LAMP_G;
      ew_lamp     <= LAMP_R;
      time_left   <= GREEN_MAX;
      phase_start <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      blink       <= blink_nxt;
      ns_lamp     <= ns_lamp_nxt;
      ew_lamp     <= ew_lamp_nxt;
      time_left   <= time_left_nxt;
      phase_start <= enter;
    end
  end

  // Flash request preempts immediately; everything else advances only on tick.
  always_comb begin
    phase_nxt = phase;
    if (mode_sel[1]) begin
      phase_nxt = FLASH;
    end else if (tick) begin
      unique case (phase)
        NS_GREEN:  if (green_done(mode_sel, veh_NS, veh_EW, elapsed, GREEN_MIN, GREEN_MAX))
                     phase_nxt = NS_YELLOW;
        NS_YELLOW: if (elapsed >= YELLOW_T - 8'd1) phase_nxt = NS_Y_NEXT;
        ALLRED_A:  if (elapsed >= ALLRED_T - 8'd1) phase_nxt = EW_GREEN;
        EW_GREEN:  if (green_done(mode_sel, veh_EW, veh_NS, elapsed, GREEN_MIN, GREEN_MAX))
                     phase_nxt = EW_YELLOW;
        EW_YELLOW: if (elapsed >= YELLOW_T - 8'd1) phase_nxt = EW_Y_NEXT;
        ALLRED_B:  if (elapsed >= ALLRED_T - 8'd1) phase_nxt = NS_GREEN;
        FLASH:     phase_nxt = FLASH_NEXT;
        default:   phase_nxt = NS_GREEN;
      endcase
    end
  end

  // Registered outputs are derived from the upcoming phase so they align with phase_id.
  always_comb begin
    blink_nxt = blink;
    if (phase_nxt == FLASH) begin
      if (phase != FLASH) blink_nxt = 1'b0;
      else if (tick)      blink_nxt = ~blink;
    end

    ns_lamp_nxt   = LAMP_R;
    ew_lamp_nxt   = LAMP_R;
    time_left_nxt = '0;
    unique case (phase_nxt)
      NS_GREEN: begin
        ns_lamp_nxt   = LAMP_G;
        time_left_nxt = (mode_sel == MODE_ACT && !veh_EW) ? 8'd0 : sat_sub(GREEN_MAX, elapsed_nxt);
      end
      NS_YELLOW: begin
        ns_lamp_nxt   = LAMP_Y;
        time_left_nxt = sat_sub(YELLOW_T, elapsed_nxt);
      end
      EW_GREEN: begin
        ew_lamp_nxt   = LAMP_G;
        time_left_nxt = (mode_sel == MODE_ACT && !veh_NS) ? 8'd0 : sat_sub(GREEN_MAX, elapsed_nxt);
      end
      EW_YELLOW: begin
        ew_lamp_nxt   = LAMP_Y;
        time_left_nxt = sat_sub(YELLOW_T, elapsed_nxt);
      end
      ALLRED_A, ALLRED_B: time_left_nxt = sat_sub(ALLRED_T, elapsed_nxt);
      FLASH: begin
        ns_lamp_nxt = blink_nxt ? LAMP_Y : LAMP_OFF;
        ew_lamp_nxt = blink_nxt ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Randomized and directed bench for tl_phase_ctrl against a behavioural phase model.
module tb_tl_phase_ctrl;

  localparam int GMIN = 5;
  localparam int GMAX = 20;
  localparam int YT   = 3;
  localparam int ART  = 1;

`ifdef TL_ALLRED_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic       veh_NS = 1'b0;
  logic       veh_EW = 1'b0;
  logic [3:0] phase_id;
  logic [2:0] ns_lamp, ew_lamp;
  logic [7:0] time_left;
  logic       phase_start;

  tl_phase_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_sel(mode_sel),
    .veh_NS(veh_NS), .veh_EW(veh_EW), .phase_id(phase_id),
    .ns_lamp(ns_lamp), .ew_lamp(ew_lamp), .time_left(time_left),
    .phase_start(phase_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_ps = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: phase number, ticks served in it, blink, derived outputs.
  int       m_ph, m_el, m_tl;
  bit       m_blink, m_start;
  int       m_ns, m_ew;
  int       seq_nxt[7];
  int       flash_exit;

  function automatic int dur(input int ph);
    if (ph == 1 || ph == 4) return YT;
    if (ph == 2 || ph == 5) return ART;
    return GMAX;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_blink = 0; m_start = 0;
    m_tl = GMAX; m_ns = 1; m_ew = 4;
  endtask

  task automatic model_edge();
    int nxt;
    bit own, opp, done;
    nxt = m_ph;
    own = (m_ph == 3) ? veh_EW : veh_NS;
    opp = (m_ph == 3) ? veh_NS : veh_EW;
    if (mode_sel[1]) nxt = 6;
    else if (tick) begin
      if (m_ph == 6) nxt = flash_exit;
      else if (m_ph == 0 || m_ph == 3) begin
        if (mode_sel == 2'b01) done = opp && ((m_el + 1 >= GMIN && !own) || m_el + 1 >= GMAX);
        else                   done = (m_el + 1 >= GMAX);
        if (done) nxt = seq_nxt[m_ph];
      end else if (m_el + 1 >= dur(m_ph)) nxt = seq_nxt[m_ph];
    end
    m_start = (nxt != m_ph);
    if (m_start) begin
      m_el = 0;
      m_blink = 0;
    end else if (tick) begin
      m_el = (m_el < 255) ? m_el + 1 : 255;
      if (nxt == 6) m_blink = ~m_blink;
    end
    m_ph = nxt;
    m_ns = 4; m_ew = 4; m_tl = 0;
    case (m_ph)
      0: m_ns = 1;
      1: m_ns = 2;
      3: m_ew = 1;
      4: m_ew = 2;
      6: begin m_ns = m_blink ? 2 : 0; m_ew = m_ns; end
      default: ;
    endcase
    if (m_ph == 0 || m_ph == 3) begin
      opp = (m_ph == 3) ? veh_NS : veh_EW;
      if (mode_sel == 2'b01 && !opp) m_tl = 0;
      else m_tl = (GMAX > m_el) ? GMAX - m_el : 0;
    end else if (m_ph != 6) m_tl = dur(m_ph) - m_el;
  endtask

  task automatic cmp_all();
    chk("phase_id", int'(phase_id), m_ph);
    chk("ns_lamp", int'(ns_lamp), m_ns);
    chk("ew_lamp", int'(ew_lamp), m_ew);
    chk("time_left", int'(time_left), m_tl);
    chk("phase_start", int'(phase_start), int'(m_start));
  endtask

  task automatic cyc(input bit t);
    tick = t;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (phase_start) n_ps++;
    cmp_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    cmp_all();
    rst = 1'b0;
  endtask

  // Count ticks applied until phase_id changes; ticks on every tick_mod-th cycle.
  task automatic run_phase(input string tag, input int exp_ticks, input int tick_mod);
    int n, c;
    logic [3:0] p0;
    bit t;
    n = 0; c = 0; p0 = phase_id;
    while (phase_id == p0 && c < 600) begin
      t = ((c % tick_mod) == tick_mod - 1);
      cyc(t);
      if (t) n++;
      c++;
    end
    chk(tag, n, exp_ticks);
  endtask

  initial begin
    int r;
    seq_nxt[0] = 1;
    seq_nxt[1] = AR_EN ? 2 : 3;
    seq_nxt[2] = 3;
    seq_nxt[3] = 4;
    seq_nxt[4] = AR_EN ? 5 : 0;
    seq_nxt[5] = 0;
    seq_nxt[6] = AR_EN ? 5 : 0;
    flash_exit = AR_EN ? 5 : 0;

    @(negedge clk);
    do_reset();
    chk("rst_phase", int'(phase_id), 0);
    chk("rst_ns_lamp", int'(ns_lamp), 1);
    chk("rst_ew_lamp", int'(ew_lamp), 4);
    chk("rst_time_left", int'(time_left), GMAX);

    // fixed mode full NS half-cycle
    n_ps = 0;
    run_phase("fixed_ns_green_ticks", GMAX, 1);
    run_phase("fixed_ns_yellow_ticks", YT, 1);
    chk("after_ns_yellow", int'(phase_id), AR_EN ? 2 : 3);
    if (AR_EN) run_phase("fixed_allred_a_ticks", ART, 1);
    chk("fixed_ew_green", int'(phase_id), 3);
    chk("phase_start_pulses", n_ps, AR_EN ? 3 : 2);

    // actuated, gap-out on the minimum
    mode_sel = 2'b01; veh_EW = 1'b1; veh_NS = 1'b0;
    do_reset();
    run_phase("act_gapout_ticks", GMIN, 2);

    // actuated, both demands held -> max-out
    veh_NS = 1'b1; veh_EW = 1'b1;
    do_reset();
    run_phase("act_maxout_ticks", GMAX, 2);

    // actuated rest in green, then opposing demand exits on the next tick
    veh_NS = 1'b1; veh_EW = 1'b0;
    do_reset();
    for (int i = 0; i < 100; i++) cyc(1'b1);
    chk("rest_phase", int'(phase_id), 0);
    chk("rest_time_left", int'(time_left), 0);
    veh_EW = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    chk("rest_exit", int'(phase_id), 1);

    // flash entry from EW_GREEN and exit
    mode_sel = 2'b00; veh_NS = 1'b0; veh_EW = 1'b0;
    do_reset();
    run_phase("to_ns_yellow", GMAX, 1);
    run_phase("to_next", YT, 1);
    if (AR_EN) run_phase("to_ew_green", ART, 1);
    cyc(1'b1); cyc(1'b1);
    mode_sel = 2'b10;
    cyc(1'b0);
    chk("flash_entry", int'(phase_id), 6);
    chk("flash_blink0", int'(ns_lamp), 0);
    cyc(1'b1);
    chk("flash_blink1", int'(ew_lamp), 2);
    cyc(1'b1);
    chk("flash_blink2", int'(ns_lamp), 0);
    mode_sel = 2'b01;
    cyc(1'b0);
    chk("flash_hold", int'(phase_id), 6);
    cyc(1'b1);
    chk("flash_exit", int'(phase_id), AR_EN ? 5 : 0);

    // asynchronous reset in NS_YELLOW
    mode_sel = 2'b00;
    do_reset();
    run_phase("pre_rst_green", GMAX, 1);
    cyc(1'b1);
    chk("in_ns_yellow", int'(phase_id), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_phase", int'(phase_id), 0);
    chk("async_rst_ns_lamp", int'(ns_lamp), 1);
    chk("async_rst_ew_lamp", int'(ew_lamp), 4);
    chk("async_rst_tl", int'(time_left), GMAX);
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 9);
        mode_sel = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r < 5) ? 2'b00 : 2'b01;
      end
      if ($urandom_range(0, 14) == 0) veh_NS = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 14) == 0) veh_EW = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_phase_ctrl.md
TL_PHASE_CTRL -- requirements
Module: tl_phase_ctrl

Interface
REQ-001 SHALL have parameter GREEN_MIN, default 8'd5, meaning minimum green duration in ticks (legal 1..GREEN_MAX).
REQ-002 SHALL have parameter GREEN_MAX, default 8'd20, meaning maximum or fixed green duration in ticks (legal GREEN_MIN..255).
REQ-003 SHALL have parameter YELLOW_T, default 8'd3, meaning yellow duration in ticks (legal 1..255).
REQ-004 SHALL have parameter ALLRED_T, default 8'd1, meaning all-red duration in ticks (legal 1..255).
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-006 SHALL have input tick, width 1, meaning a 1-cycle timing strobe that is the only time base.
REQ-007 SHALL have input mode_sel, width 2: 00 fixed, 01 actuated, 10 and 11 flash.
REQ-008 SHALL have inputs veh_NS and veh_EW, width 1 each, meaning latched vehicle demand levels.
REQ-009 SHALL have output phase_id, width 4, meaning current phase code, registered.
REQ-010 SHALL have outputs ns_lamp and ew_lamp, width 3 each, meaning {R,Y,G} one-hot or all-off, registered.
REQ-011 SHALL have output time_left, width 8, meaning ticks remaining in the current timed phase.
REQ-012 SHALL have output phase_start, width 1, meaning a 1-cycle pulse in the first cycle of each new phase.

Function
REQ-013 SHALL implement phases NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, FLASH=6.
REQ-014 SHALL keep an 8-bit elapsed counter: cleared on phase entry, +1 on tick, saturating at 255.
REQ-015 SHALL evaluate transitions only on tick cycles; the new phase is visible one cycle after the deciding tick.
REQ-016 SHALL end a timed phase of duration D (yellow or all-red) on the tick where elapsed==D-1, so the phase lasts exactly D ticks.
REQ-017 SHALL follow this sequence: NS_GREEN->NS_YELLOW->ALLRED_A->EW_GREEN->EW_YELLOW->ALLRED_B->NS_GREEN.
REQ-018 SHALL end green in fixed mode on the tick where elapsed==GREEN_MAX-1, regardless of demand.
REQ-019 SHALL end green in actuated mode on a tick when opposing demand=1 and either (elapsed>=GREEN_MIN-1 and own demand=0) or elapsed>=GREEN_MAX-1.
REQ-020 SHALL keep green in actuated mode with opposing demand=0 (rest in green); time_left=0 while resting.
REQ-021 SHALL enter FLASH from any phase in the next cycle when mode_sel is 1x, without waiting for a tick; elapsed is cleared.
REQ-022 SHALL toggle a blink bit on each tick in FLASH; ns_lamp=ew_lamp={0,blink,0}; blink=0 on FLASH entry.
REQ-023 SHALL leave FLASH to ALLRED_B on the first tick with mode_sel 0x, then continue the normal sequence.
REQ-024 SHALL drive lamps from phase: green phase -> own G, other R; yellow -> own Y, other R; all-red -> both R.
REQ-025 SHALL set time_left=D-elapsed in timed phases, GREEN_MAX-elapsed in fixed and actuated green (0 when resting), and 0 in FLASH.
REQ-026 SHALL let a mode change between fixed and actuated take effect at the next tick evaluation, with no phase restart.

Reset
REQ-027 SHALL on rst asynchronously set phase_id=NS_GREEN, elapsed=0, blink=0, ns_lamp=001, ew_lamp=100, phase_start=0, time_left=GREEN_MAX.
REQ-028 SHALL on rst mid-phase abandon the phase immediately, with no yellow or all-red clearance.

Configuration
REQ-029 SHALL support macro TL_ALLRED_EN: when defined, all-red phases are included per REQ-017.
REQ-030 SHALL, without TL_ALLRED_EN, go from yellow directly to the opposing green; FLASH exit then goes to NS_GREEN; ALLRED_A and ALLRED_B are unreachable and ALLRED_T is unused.

Structure
REQ-031 SHALL place phase codes, mode codes and lamp encodings in shared package tl_pkg.
REQ-032 SHALL place the elapsed counter in sub-module tl_phase_timer (clear, tick, saturate).

Verification
REQ-033 SHALL cover fixed mode, defaults: NS_GREEN lasts 20 ticks, NS_YELLOW 3 ticks, ALLRED_A 1 tick, then EW_GREEN; phase_start pulses once per phase.
REQ-034 SHALL cover actuated mode, veh_EW=1 and veh_NS=0 from reset: NS_GREEN ends on the 5th tick.
REQ-035 SHALL cover actuated mode, veh_NS=veh_EW=1 held: NS_GREEN ends on the 20th tick (max-out).
REQ-036 SHALL cover actuated mode, veh_EW=0: NS_GREEN rests for 100 ticks with time_left=0; asserting veh_EW with elapsed>=4 exits on the next tick.
REQ-037 SHALL cover mode_sel=10 mid EW_GREEN: FLASH next cycle with blink toggling per tick; mode_sel=01 -> ALLRED_B on the next tick.
REQ-038 SHALL cover rst pulsed in NS_YELLOW: immediate NS_GREEN with ns_lamp=001; build without TL_ALLRED_EN shows NS_YELLOW->EW_GREEN directly.
